// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: write-back source selects, CP0 opcodes and the
// multiply/divide sequencer state type.
package pipe_pkg;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_CP0 = 2'd2;

    localparam logic [2:0] MFC0 = 3'b001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

    // A producer hits a source only if it really writes a non-zero register.
    function automatic logic reg_match(logic [4:0] src, logic [4:0] rw, logic wr);
        return wr && (rw != 5'd0) && (rw == src);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle for hazard_unit; slave is the hazard unit,
// master is the pipeline (or a bench standing in for it).
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_hilo_use;
    logic [4:0]       ex_rw;
    logic [4:0]       mem_rw;
    logic             ex_regWr;
    logic             mem_regWr;
    logic [1:0]       ex_memtoreg;
    logic [1:0]       mem_memtoreg;
    logic             md_start;
    logic             md_is_div;
    logic             exc_flush;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             md_busy;
    logic             md_done;
    logic             md_overrun;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_use,
        output ex_rw, mem_rw, ex_regWr, mem_regWr, ex_memtoreg, mem_memtoreg,
        output md_start, md_is_div, exc_flush,
        input  pc_write, ifid_write, ifid_flush, idex_bubble,
        input  md_busy, md_done, md_overrun, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_use,
        input  ex_rw, mem_rw, ex_regWr, mem_regWr, ex_memtoreg, mem_memtoreg,
        input  md_start, md_is_div, exc_flush,
        output pc_write, ifid_write, ifid_flush, idex_bubble,
        output md_busy, md_done, md_overrun, stall_cycles
    );

endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: tracks the in-flight HI/LO operation, pulses
// md_done when it completes and flags starts that arrive while busy.
module md_sequencer
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    input  logic md_is_div,
    input  logic exc_flush,
    output logic md_busy,
    output logic md_done,
    output logic md_overrun
);

    localparam int unsigned CW = $clog2(DIV_LAT);
    // BUSY spans LAT-1 cycles and DONE is the LAT-th, so the count starts at LAT-2.
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q | (md_start && (state_q == BUSY));
        if (exc_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (md_start) begin
                        state_d = BUSY;
                        cnt_d   = md_is_div ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) state_d = DONE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign md_busy    = (state_q == BUSY);
    assign md_done    = (state_q == DONE);
    assign md_overrun = ovr_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush generator: holds dependent ID instructions that forwarding
// cannot serve, sequences mult/div and applies exception flushes.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input logic         clk,
    input logic         rst,
    hazard_unit_if.slave bus
);

    logic ex_hit, mem_hit;
    logic load_stall, cp0_stall, md_stall, stall;
    logic md_busy;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    md_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_sequencer (
        .clk        (clk),
        .rst        (rst),
        .md_start   (bus.md_start),
        .md_is_div  (bus.md_is_div),
        .exc_flush  (bus.exc_flush),
        .md_busy    (md_busy),
        .md_done    (bus.md_done),
        .md_overrun (bus.md_overrun)
    );

    assign ex_hit  = (bus.id_use_rs && reg_match(bus.id_rs, bus.ex_rw, bus.ex_regWr)) ||
                     (bus.id_use_rt && reg_match(bus.id_rt, bus.ex_rw, bus.ex_regWr));
    assign mem_hit = (bus.id_use_rs && reg_match(bus.id_rs, bus.mem_rw, bus.mem_regWr)) ||
                     (bus.id_use_rt && reg_match(bus.id_rt, bus.mem_rw, bus.mem_regWr));

    // A load in MEM is forwardable; CP0 data only appears at WB, so MEM must still wait.
    assign load_stall = ex_hit && (bus.ex_memtoreg == MTR_MEM);
    assign cp0_stall  = (ex_hit && (bus.ex_memtoreg == MTR_CP0)) ||
                        (mem_hit && (bus.mem_memtoreg == MTR_CP0));
    assign md_stall   = bus.id_hilo_use && (md_busy || bus.md_start);
    assign stall      = load_stall || cp0_stall || md_stall;

    always_comb begin
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        if (bus.exc_flush) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (stall) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !bus.exc_flush && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.md_busy      = md_busy;
    assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a cycle-level reference model that is
// compared against the DUT on every falling edge.
module tb_hazard_unit;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 32;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_unit #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op finishes at a known absolute cycle number.
    bit m_active   = 1'b0;
    int m_cyc      = 0;
    int m_done_cyc = 0;
    bit m_ovr      = 1'b0;
    int m_cnt      = 0;

    function automatic bit m_busy();
        return m_active && (m_cyc < m_done_cyc);
    endfunction

    function automatic bit m_done();
        return m_active && (m_cyc == m_done_cyc);
    endfunction

    function automatic bit hit(logic [4:0] rw, logic wr);
        bit rs_hit, rt_hit;
        rs_hit = bus.id_use_rs && wr && rw != 0 && rw == bus.id_rs;
        rt_hit = bus.id_use_rt && wr && rw != 0 && rw == bus.id_rt;
        return rs_hit || rt_hit;
    endfunction

    function automatic bit m_stall();
        bit ld, cp0, md;
        ld  = hit(bus.ex_rw, bus.ex_regWr) && bus.ex_memtoreg == 2'd1;
        cp0 = (hit(bus.ex_rw, bus.ex_regWr) && bus.ex_memtoreg == 2'd2) ||
              (hit(bus.mem_rw, bus.mem_regWr) && bus.mem_memtoreg == 2'd2);
        md  = bus.id_hilo_use && (m_busy() || bus.md_start);
        return ld || cp0 || md;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_cyc    <= 0;
            m_ovr    <= 1'b0;
            m_cnt    <= 0;
        end else begin
            if (m_stall() && !bus.exc_flush && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
            if (bus.md_start && m_busy()) m_ovr <= 1'b1;
            if (bus.exc_flush) begin
                m_active <= 1'b0;
            end else if (bus.md_start && !m_busy()) begin
                m_active   <= 1'b1;
                m_done_cyc <= m_cyc + (bus.md_is_div ? DIV_LAT : MUL_LAT);
            end
            m_cyc <= m_cyc + 1;
        end
    end

    logic [3:0] e_ctl;  // {pc_write, ifid_write, ifid_flush, idex_bubble}

    always @(negedge clk) begin
        if (bus.exc_flush)  e_ctl = 4'b1111;
        else if (m_stall()) e_ctl = 4'b0001;
        else                e_ctl = 4'b1100;
        chk("pc_write",     32'(bus.pc_write),     32'(e_ctl[3]));
        chk("ifid_write",   32'(bus.ifid_write),   32'(e_ctl[2]));
        chk("ifid_flush",   32'(bus.ifid_flush),   32'(e_ctl[1]));
        chk("idex_bubble",  32'(bus.idex_bubble),  32'(e_ctl[0]));
        chk("md_busy",      32'(bus.md_busy),      32'(m_busy()));
        chk("md_done",      32'(bus.md_done),      32'(m_done()));
        chk("md_overrun",   32'(bus.md_overrun),   32'(m_ovr));
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_cnt));
    end

    task automatic clr();
        bus.id_rs = '0;        bus.id_rt = '0;
        bus.id_use_rs = 1'b0;  bus.id_use_rt = 1'b0;  bus.id_hilo_use = 1'b0;
        bus.ex_rw = '0;        bus.mem_rw = '0;
        bus.ex_regWr = 1'b0;   bus.mem_regWr = 1'b0;
        bus.ex_memtoreg = '0;  bus.mem_memtoreg = '0;
        bus.md_start = 1'b0;   bus.md_is_div = 1'b0;  bus.exc_flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        #2;
        chk("rst_stall_cycles", 32'(bus.stall_cycles), 0);
        chk("rst_md_busy", 32'(bus.md_busy), 0);
        chk("rst_pc_write", 32'(bus.pc_write), 1);
        #10 rst = 1'b0;
        tick();

        // Load r5 in EX, add in ID reads rs=5: one bubble, then forwarding from MEM.
        bus.ex_rw = 5'd5; bus.ex_regWr = 1'b1; bus.ex_memtoreg = 2'd1;
        bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
        #2 chk("load_stall_pc", 32'(bus.pc_write), 0);
        chk("load_stall_bubble", 32'(bus.idex_bubble), 1);
        tick();
        bus.mem_rw = 5'd5; bus.mem_regWr = 1'b1; bus.mem_memtoreg = 2'd1;
        bus.ex_rw = 5'd0; bus.ex_regWr = 1'b0; bus.ex_memtoreg = 2'd0;
        #2 chk("load_in_mem_pc", 32'(bus.pc_write), 1);
        tick();
        clr();
        bus.ex_rw = 5'd0; bus.ex_regWr = 1'b1; bus.ex_memtoreg = 2'd1;
        bus.id_rs = 5'd0; bus.id_use_rs = 1'b1;
        #2 chk("load_r0_pc", 32'(bus.pc_write), 1);
        tick();

        // mfc0 r8: dependent rt=8 waits through EX and MEM.
        clr();
        bus.ex_rw = 5'd8; bus.ex_regWr = 1'b1; bus.ex_memtoreg = 2'd2;
        bus.id_rt = 5'd8; bus.id_use_rt = 1'b1;
        #2 chk("cp0_ex_pc", 32'(bus.pc_write), 0);
        tick();
        bus.mem_rw = 5'd8; bus.mem_regWr = 1'b1; bus.mem_memtoreg = 2'd2;
        bus.ex_rw = 5'd0; bus.ex_regWr = 1'b0; bus.ex_memtoreg = 2'd0;
        #2 chk("cp0_mem_pc", 32'(bus.pc_write), 0);
        tick();
        bus.mem_rw = 5'd0; bus.mem_regWr = 1'b0; bus.mem_memtoreg = 2'd0;
        #2 chk("cp0_wb_pc", 32'(bus.pc_write), 1);
        tick();

        // Divide with dependent mfhi in ID from the start cycle.
        clr();
        bus.md_start = 1'b1; bus.md_is_div = 1'b1; bus.id_hilo_use = 1'b1;
        #2 chk("div_start_pc", 32'(bus.pc_write), 0);
        tick();
        bus.md_start = 1'b0;
        for (int i = 1; i < DIV_LAT; i++) begin
            #2 chk("div_busy", 32'(bus.md_busy), 1);
            chk("div_mfhi_held", 32'(bus.ifid_write), 0);
            chk("div_no_done", 32'(bus.md_done), 0);
            tick();
        end
        #2 chk("div_done", 32'(bus.md_done), 1);
        chk("div_done_busy", 32'(bus.md_busy), 0);
        chk("div_done_release", 32'(bus.pc_write), 1);
        tick();
        bus.id_hilo_use = 1'b0;
        #2 chk("div_done_pulse", 32'(bus.md_done), 0);
        tick();

        // Multiply aborted by exc_flush on its third (last) BUSY cycle.
        clr();
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        tick();
        tick();
        bus.exc_flush = 1'b1;
        #2 chk("exc_ifid_flush", 32'(bus.ifid_flush), 1);
        chk("exc_pc_write", 32'(bus.pc_write), 1);
        chk("exc_bubble", 32'(bus.idex_bubble), 1);
        tick();
        bus.exc_flush = 1'b0;
        #2 chk("exc_idle", 32'(bus.md_busy), 0);
        chk("exc_no_done", 32'(bus.md_done), 0);
        tick();
        #2 chk("exc_no_done2", 32'(bus.md_done), 0);
        tick();

        // Second start while busy: sticky overrun, original timing kept.
        clr();
        bus.md_start = 1'b1;
        tick();
        tick();
        bus.md_start = 1'b0;
        #2 chk("ovr_set", 32'(bus.md_overrun), 1);
        tick();
        tick();
        #2 chk("ovr_done_on_time", 32'(bus.md_done), 1);
        tick();
        #2 chk("ovr_held", 32'(bus.md_overrun), 1);
        chk("ovr_no_second_op", 32'(bus.md_busy), 0);
        tick();

        // Continuous load-use stall saturates the counter.
        clr();
        bus.ex_rw = 5'd3; bus.ex_regWr = 1'b1; bus.ex_memtoreg = 2'd1;
        bus.id_rs = 5'd3; bus.id_use_rs = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
        #2 chk("cnt_saturated", 32'(bus.stall_cycles), CNT_MAX);
        tick();

        // Reset mid-divide clears every registered output at once.
        clr();
        bus.md_start = 1'b1; bus.md_is_div = 1'b1;
        tick();
        bus.md_start = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", 32'(bus.md_busy), 1);
        rst = 1'b1;
        #1 chk("arst_busy", 32'(bus.md_busy), 0);
        chk("arst_done", 32'(bus.md_done), 0);
        chk("arst_overrun", 32'(bus.md_overrun), 0);
        chk("arst_cnt", 32'(bus.stall_cycles), 0);
        #1 rst = 1'b0;
        for (int i = 0; i < DIV_LAT + 4; i++) begin
            tick();
            #2 chk("arst_no_done", 32'(bus.md_done), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall and flush generator for the five-stage pipeline; the producer-side counterpart to operand forwarding. It decides when a dependent instruction in ID cannot be served by forwarding and must wait (load-use, CP0 read, multiply/divide in flight). It sequences the multi-cycle multiply/divide unit and applies exception flushes. It sits between the ID/EX pipeline registers and the PC/IF-ID write enables.

## Interface
- MUL_LAT, 4, multiply latency in cycles (≥2)
- DIV_LAT, 32, divide latency in cycles (≥2, ≥MUL_LAT)
- CNT_W, 16, width of the stall performance counter

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  5  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- id_hilo_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
- ex_rw, mem_rw  in  5  destination register in EX / MEM
- ex_regWr, mem_regWr  in  1  register write enable in EX / MEM
- ex_memtoreg, mem_memtoreg  in  2  write-back source: 0 ALU, 1 data memory, 2 CP0
- md_start  in  1  EX holds mult/div this cycle
- md_is_div  in  1  qualifies md_start: 1 divide, 0 multiply
- exc_flush  in  1  exception/eret redirect this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register write enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- md_busy  out  1  multiply/divide in progress (registered)
- md_done  out  1  one-cycle pulse: HI/LO written at end of this cycle (registered)
- md_overrun  out  1  sticky: md_start seen while busy (registered)
- stall_cycles  out  CNT_W  saturating count of stalled cycles

## Operation
- Match(x, rw, wr) = wr && rw≠0 && rw==x; applies to rs only if id_use_rs, to rt only if id_use_rt.
- load_stall = match against EX with ex_memtoreg==1.
- cp0_stall = match against EX with ex_memtoreg==2, or against MEM with mem_memtoreg==2. CP0 data exists only at WR, so a dependent instruction waits 2 cycles after mfc0.
- Load in MEM never stalls; forwarding serves it.
- md_stall = id_hilo_use && (state==BUSY || md_start).
- stall = load_stall | cp0_stall | md_stall.
- Outputs when stalling: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- exc_flush overrides stall: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
- Outputs otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Sequencer FSM:
  - IDLE → BUSY on md_start (no exc_flush). Counter loads DIV_LAT-2 for divide, MUL_LAT-2 for multiply.
  - BUSY: counter decrements; at 0 → DONE.
  - DONE: md_done=1 for one cycle, then IDLE. A new md_start in DONE is accepted: DONE → BUSY.
  - exc_flush in any state → IDLE, counter 0; no md_done for the aborted op.
- md_start while BUSY is ignored; sets md_overrun, cleared only by rst.
- md_busy = (state==BUSY).
- stall_cycles increments each cycle stall && !exc_flush, saturates at all-ones.
- Counter width is $clog2(DIV_LAT).

## Timing
- Stall/flush outputs are combinational from inputs and current state, with zero latency.
- md_done rises exactly L cycles after the md_start cycle, where L = MUL_LAT or DIV_LAT.
- A dependent mfhi in ID during the md_start cycle stalls through the last BUSY cycle. It leaves ID in the DONE cycle.
- Reset values: state IDLE, counter 0, md_busy 0, md_done 0, md_overrun 0, stall_cycles 0. Combinational outputs then follow the IDLE rules.
- rst mid-operation aborts immediately with no md_done.

## Structure
- Shared package pipe_pkg holds:
  - memtoreg encodings MTR_ALU=0, MTR_MEM=1, MTR_CP0=2;
  - CP0 op MFC0=3'b001;
  - sequencer state enum {IDLE, BUSY, DONE}.
- One sub-module, md_sequencer (FSM + latency counter + md_done/md_overrun), instantiated once.
- Hazard compare logic and stall counter live in the top.

## Test plan
- Load of r5 in EX, ID add uses rs=5 → exactly 1 cycle: pc_write=0, idex_bubble=1; same with rd=0 → no stall.
- mfc0 to r8 in EX, ID uses rt=8 → stall 2 consecutive cycles (EX then MEM match), released on third.
- md_start with md_is_div=1, mfhi following → md_busy high 31 cycles, md_done pulses on cycle 32, mfhi stalled until the DONE cycle.
- Multiply, exc_flush on third BUSY cycle → ifid_flush=1, pc_write=1, state IDLE, no md_done.
- md_start while BUSY → md_overrun=1 and held; md_done timing of original op unchanged.
- Hold stall continuously 2^CNT_W+5 cycles → stall_cycles saturates at all-ones; rst asserted mid-run → all registered outputs 0 asynchronously.
